// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled mid-bit sampling, optional parity, 1/2 stop bits,
// feeding a show-ahead receive FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned OSR        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic [15:0]                   divider_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          two_stop_i,
  input  logic                          flush_i,
  input  logic                          rd_en_i,
  input  logic                          err_clr_i,
  output logic [DATA_W-1:0]             rd_data_o,
  output logic                          rd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          parity_err_o,
  output logic                          framing_err_o,
  output logic                          overrun_err_o,
  output logic                          busy_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(OSR);
  localparam int unsigned BW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_SHIFT, RX_PARITY, RX_STOP} state_t;

  state_t              state, state_n;
  logic                rx_s1, rx_s2, rx_q;
  logic [15:0]         div_cnt, div_m1;
  logic                tick;
  logic [OW-1:0]       os_cnt, os_cnt_n;
  logic [BW-1:0]       bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic                cfg_par, cfg_par_n, cfg_odd, cfg_odd_n, cfg_two, cfg_two_n;
  logic                par_bad, par_bad_n, fr_bad, fr_bad_n;
  logic                done, mid_half, mid_full;
  logic                push_req, push_par, fr_ev;
  logic [DATA_W-1:0]   push_word;

  // Synchronizer plus one extra stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  assign div_m1 = (divider_i == 16'd0) ? 16'd0 : 16'(divider_i - 16'd1);
  assign tick   = (state != RX_IDLE) && (div_cnt == div_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         div_cnt <= 16'd0;
    else if (state == RX_IDLE || tick)  div_cnt <= 16'd0;
    else                                div_cnt <= 16'(div_cnt + 16'd1);
  end

  assign mid_half = tick && (os_cnt == OW'(OSR / 2 - 1));
  assign mid_full = tick && (os_cnt == OW'(OSR - 1));

  always_comb begin
    state_n   = state;
    os_cnt_n  = os_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    cfg_par_n = cfg_par;
    cfg_odd_n = cfg_odd;
    cfg_two_n = cfg_two;
    par_bad_n = par_bad;
    fr_bad_n  = fr_bad;
    done      = 1'b0;
    if (tick) os_cnt_n = OW'(os_cnt + 1'b1);
    case (state)
      RX_IDLE: begin
        os_cnt_n  = '0;
        bit_cnt_n = '0;
        if (rx_q && !rx_s2) begin
          state_n   = RX_START;
          cfg_par_n = parity_en_i;
          cfg_odd_n = parity_odd_i;
          cfg_two_n = two_stop_i;
          par_bad_n = 1'b0;
          fr_bad_n  = 1'b0;
        end
      end
      RX_START: begin
        if (mid_half) begin
          os_cnt_n = '0;
          state_n  = rx_s2 ? RX_IDLE : RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (mid_full) begin
          os_cnt_n  = '0;
          shreg_n   = {rx_s2, shreg[DATA_W-1:1]};
          bit_cnt_n = BW'(bit_cnt + 1'b1);
          if (bit_cnt == BW'(DATA_W - 1)) begin
            bit_cnt_n = '0;
            state_n   = cfg_par ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (mid_full) begin
          os_cnt_n  = '0;
          par_bad_n = rx_s2 != ((^shreg) ^ cfg_odd);
          state_n   = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leave at the last stop-bit centre so the next start edge is caught early
        if (mid_full) begin
          os_cnt_n = '0;
          fr_bad_n = fr_bad | !rx_s2;
          if (!cfg_two || bit_cnt == BW'(1)) begin
            state_n = RX_IDLE;
            done    = 1'b1;
          end else begin
            bit_cnt_n = BW'(bit_cnt + 1'b1);
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      cfg_par   <= 1'b0;
      cfg_odd   <= 1'b0;
      cfg_two   <= 1'b0;
      par_bad   <= 1'b0;
      fr_bad    <= 1'b0;
      push_req  <= 1'b0;
      push_par  <= 1'b0;
      fr_ev     <= 1'b0;
      push_word <= '0;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_n;
      os_cnt    <= os_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      cfg_par   <= cfg_par_n;
      cfg_odd   <= cfg_odd_n;
      cfg_two   <= cfg_two_n;
      par_bad   <= par_bad_n;
      fr_bad    <= fr_bad_n;
      push_req  <= done && !fr_bad_n;
      push_par  <= done && !fr_bad_n && par_bad_n;
      fr_ev     <= done && fr_bad_n;
      push_word <= shreg_n;
      busy_o    <= state_n != RX_IDLE;
    end
  end

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0]     count_n;
  logic [DATA_W-1:0] head_n;
  logic              pop_ok, wr_ok, ovr_ev;

  // FIFO pointer/occupancy update and registered show-ahead head
  always_comb begin
    pop_ok   = rd_en_i && rd_valid_o;
    wr_ok    = push_req && !flush_i && (!full_o || pop_ok);
    ovr_ev   = push_req && !flush_i && full_o && !pop_ok;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count_o;
    if (flush_i) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (wr_ok)  wr_ptr_n = AW'(wr_ptr + 1'b1);
      if (pop_ok) rd_ptr_n = AW'(rd_ptr + 1'b1);
      count_n = CW'(count_o + CW'(wr_ok) - CW'(pop_ok));
    end
    if (count_n == '0)                      head_n = '0;
    else if (wr_ok && wr_ptr == rd_ptr_n)   head_n = push_word;
    else                                    head_n = mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_o       <= '0;
      full_o        <= 1'b0;
      empty_o       <= 1'b1;
      rd_valid_o    <= 1'b0;
      rd_data_o     <= '0;
      parity_err_o  <= 1'b0;
      framing_err_o <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      count_o    <= count_n;
      full_o     <= count_n == CW'(FIFO_DEPTH);
      empty_o    <= count_n == '0;
      rd_valid_o <= count_n != '0;
      rd_data_o  <= head_n;
      if (push_par)       parity_err_o <= 1'b1;
      else if (err_clr_i) parity_err_o <= 1'b0;
      if (fr_ev)          framing_err_o <= 1'b1;
      else if (err_clr_i) framing_err_o <= 1'b0;
      if (ovr_ev)         overrun_err_o <= 1'b1;
      else if (err_clr_i) overrun_err_o <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter OSR, default 16, oversample ticks per bit (even, >=8).
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset. Reset is asynchronous and active-low; one clock domain.
REQ-005 SHALL have ports: rx_i  in  1  serial line (asynchronous, idle high); divider_i  in  16  clk cycles per oversample tick.
REQ-006 SHALL have ports: parity_en_i  in  1  parity bit present; parity_odd_i  in  1  1=odd, 0=even; two_stop_i  in  1  two stop bits.
REQ-007 SHALL have ports: flush_i  in  1  clear FIFO; rd_en_i  in  1  pop head; err_clr_i  in  1  clear sticky errors.
REQ-008 SHALL have ports: rd_data_o  out  DATA_W  FIFO head; rd_valid_o  out  1  FIFO not empty; count_o  out  $clog2(FIFO_DEPTH)+1  occupancy.
REQ-009 SHALL have ports: full_o  out  1; empty_o  out  1; parity_err_o, framing_err_o, overrun_err_o  out  1 each  sticky flags; busy_o  out  1  frame in progress.

Function
REQ-010 SHALL pass rx_i through a 2-flop synchronizer, reset value 1; all decoding uses the synchronized value.
REQ-011 SHALL generate a 1-cycle tick every divider_i clk cycles; divider_i=0 treated as 1; counter held at 0 in RX_IDLE.
REQ-012 SHALL implement FSM states RX_IDLE, RX_START, RX_SHIFT, RX_PARITY, RX_STOP.
REQ-013 RX_IDLE -> RX_START on synchronized high-to-low transition; parity_en/odd, two_stop latched at this cycle; config changes mid-frame have no effect.
REQ-014 RX_START: sample at tick OSR/2; low -> RX_SHIFT; high -> false start, return to RX_IDLE, no flags, no push.
REQ-015 RX_SHIFT: sample every OSR ticks (mid-bit), LSB first, DATA_W bits; then RX_PARITY if parity latched, else RX_STOP.
REQ-016 RX_PARITY: one mid-bit sample; mismatch vs XOR of data (inverted if odd) sets parity error for the frame.
REQ-017 RX_STOP: one or two mid-bit samples; any low sample = framing error; return to RX_IDLE at last stop-bit mid-sample (half bit early, for resync).
REQ-018 Frame with framing error SHALL be discarded and set framing_err_o; frame with parity error only SHALL be pushed and set parity_err_o.
REQ-019 Push SHALL occur the cycle after last stop mid-sample; rd_valid_o high the following cycle (1-cycle push latency).
REQ-020 FIFO is show-ahead: rd_data_o = head whenever rd_valid_o=1; rd_en_i while empty ignored.
REQ-021 Push while full and no pop in same cycle: word dropped, overrun_err_o set, FIFO unchanged.
REQ-022 Simultaneous push and pop: count unchanged, legal when full and when empty-with-push-only (pop ignored if empty).
REQ-023 Pointers wrap modulo FIFO_DEPTH; count_o ranges 0..FIFO_DEPTH; full_o = (count==FIFO_DEPTH), empty_o = (count==0).
REQ-024 flush_i clears pointers and count next cycle; a push in the same cycle is dropped (no overrun); FSM not affected.
REQ-025 Sticky flags cleared by err_clr_i; set event in same cycle as clear wins.
REQ-026 busy_o = 1 in every state except RX_IDLE.

Reset
REQ-027 On rst_n low, asynchronously: FSM RX_IDLE, tick counter 0, synchronizer 1, FIFO empty (count_o 0, empty_o 1, full_o 0, rd_valid_o 0, rd_data_o 0), all error flags 0, busy_o 0.
REQ-028 Reset mid-frame SHALL abandon the frame; no partial word pushed after release.

Verification
REQ-029 divider=1, OSR=16, 8N1, send 0xA5 -> rd_valid_o rises 150-156 clk after rx fall, rd_data_o=0xA5, no flags.
REQ-030 8E1, send 0x03 with parity bit 1 -> word 0x03 pushed, parity_err_o=1; err_clr_i pulse -> flag 0.
REQ-031 8N2, second stop bit low -> no push, framing_err_o=1, count_o stays 0.
REQ-032 FIFO_DEPTH=4, send 5 frames without reads -> count_o=4, full_o=1, overrun_err_o=1, head = first byte.
REQ-033 rx low pulse of 4 clk (divider=1) -> FSM returns RX_IDLE, no push, no flags.
REQ-034 rst_n asserted at data bit 3 -> all outputs at reset values; next full frame after release received correctly.
